// File: rtl/abcd_seq_pkg.sv
// rtl/abcd_seq_pkg.sv - shared widths and debounce state type for abcd_sequencer
package abcd_seq_pkg;

    localparam int CODE_W = 4;
    localparam int DC_W   = 16;
    localparam int PC_W   = 24;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } dbnc_state_t;

endpackage

// File: rtl/abcd_sequencer_btn_debounce.sv
// rtl/abcd_sequencer_btn_debounce.sv - push-button synchronizer and debounce FSM producing one step per press
module btn_debounce
    import abcd_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic step_pulse
);

    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic [1:0]      fill;
    logic            armed;
    dbnc_state_t     state;
    dbnc_state_t     state_nxt;
    logic [DC_W-1:0] dc;
    logic [DC_W-1:0] dc_nxt;
    logic            step_nxt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // After reset, wait for the synchronizer to refill and then for the button
    // to be seen released, so a press that straddled reset never yields a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill  <= 2'd0;
            armed <= 1'b0;
        end else if (fill != 2'd2) begin
            fill <= fill + 2'd1;
        end else if (!s2) begin
            armed <= 1'b1;
        end
    end

    // Debounce state, counter and registered step pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RELEASED;
            dc         <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            dc         <= dc_nxt;
            step_pulse <= step_nxt;
        end
    end

    // Next-state logic: a press or release must hold DEBOUNCE_CYCLES cycles in
    // its wait state; only the press edge produces a step.
    always_comb begin
        state_nxt = state;
        dc_nxt    = dc;
        step_nxt  = 1'b0;
        case (state)
            RELEASED: begin
                if (armed && s2) begin
                    state_nxt = PRESS_WAIT;
                    dc_nxt    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nxt = RELEASED;
                end else if (dc == DC_LAST) begin
                    state_nxt = PRESSED;
                    step_nxt  = 1'b1;
                end else begin
                    dc_nxt = dc + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nxt = RELEASE_WAIT;
                    dc_nxt    = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_nxt = PRESSED;
                end else if (dc == DC_LAST) begin
                    state_nxt = RELEASED;
                end else begin
                    dc_nxt = dc + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                dc_nxt    = '0;
            end
        endcase
    end

endmodule

// File: rtl/abcd_sequencer.sv
// rtl/abcd_sequencer.sv - 4-bit code stepper (button/auto-run/load); auto-run built only with SEQ_AUTO_RUN_EN
module abcd_sequencer
    import abcd_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_DIV        = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_btn,
    input  logic              load,
    input  logic [CODE_W-1:0] load_val,
    input  logic              run,
    output logic              A,
    output logic              B,
    output logic              C,
    output logic              D,
    output logic              upd
);

    logic              step;
    logic              tick;
    logic [CODE_W-1:0] cnt;
    logic [CODE_W-1:0] cnt_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (step_btn),
        .step_pulse(step)
    );

`ifdef SEQ_AUTO_RUN_EN
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(AUTO_DIV - 1);

    logic [PC_W-1:0] pc;

    // Free-running prescaler: one tick every AUTO_DIV cycles while run is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= '0;
            tick <= 1'b0;
        end else if (!run) begin
            pc   <= '0;
            tick <= 1'b0;
        end else if (pc == PC_LAST) begin
            pc   <= '0;
            tick <= 1'b1;
        end else begin
            pc   <= pc + 1'b1;
            tick <= 1'b0;
        end
    end
`else
    logic            unused_run;
    logic [PC_W-1:0] unused_div;

    assign unused_run = run;
    assign unused_div = PC_W'(AUTO_DIV - 1);
    assign tick       = 1'b0;
`endif

    // Load wins over step/tick; a step and tick together count once.
    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_val;
        end else if (step || tick) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Code register and its update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            upd <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            upd <= load | step | tick;
        end
    end

    assign A = cnt[3];
    assign B = cnt[2];
    assign C = cnt[1];
    assign D = cnt[0];

endmodule

// File: tb/tb_abcd_sequencer.sv
// tb/tb_abcd_sequencer.sv - scoreboard bench for abcd_sequencer
module tb_abcd_sequencer;

    localparam int DBN = 4;
    localparam int DIV = 5;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step_btn;
    logic       load;
    logic [3:0] load_val;
    logic       run;
    logic       A, B, C, D;
    logic       upd;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   cur_code = 0;
    int   exp_cnt = 0;
    exp_t sbq[$];

    abcd_sequencer #(
        .DEBOUNCE_CYCLES(DBN),
        .AUTO_DIV       (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_btn(step_btn),
        .load    (load),
        .load_val(load_val),
        .run     (run),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int code_now();
        return int'({A, B, C, D});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    // Monitor: every update is matched against the oldest expected update;
    // between updates the code must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cur_code = 0;
            chk("reset_code", code_now(), 0);
            chk("reset_upd", int'(upd), 0);
        end else if (upd) begin
            if (sbq.size() == 0) begin
                chk("unexpected_upd", code_now(), cur_code);
                chk("upd_with_empty_queue", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("upd_code", code_now(), e.code);
                chk("upd_cycle", cyc, e.cyc);
                cur_code = e.code;
            end
        end else begin
            chk("hold_code", code_now(), cur_code);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A press held for at least DBN+1 samples steps the code; the step lands
    // DBN+3 edges after the first sampled high.
    task automatic press(input int hold);
        int n;
        @(negedge clk);
        n = cyc;
        step_btn = 1'b1;
        if (hold >= DBN + 1) begin
            exp_cnt = (exp_cnt + 1) % 16;
            push_exp(exp_cnt, n + 1 + DBN + 3);
        end
        repeat (hold) @(negedge clk);
        step_btn = 1'b0;
        idle(2 * DBN + 6);
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        load     = 1'b1;
        load_val = 4'(v);
        exp_cnt  = v;
        push_exp(v, cyc + 1);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        step_btn = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        run      = 1'b0;
        @(negedge clk);
        chk("por_code", code_now(), 0);
        chk("por_upd", int'(upd), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(6);

        // Held button gives exactly one step.
        press(20);

        // Short glitches never step.
        repeat (5) press(3);

        // Threshold boundary: DBN samples rejected, DBN+1 accepted.
        press(DBN);
        press(DBN + 1);

        // Wrap from 15 to 0.
        do_load(15);
        idle(2);
        press(6);

        // Load coincident with the internal step: load wins, single update.
        @(negedge clk);
        n = cyc;
        step_btn = 1'b1;
        repeat (DBN + 3) @(negedge clk);
        load     = 1'b1;
        load_val = 4'b1010;
        exp_cnt  = 10;
        push_exp(10, n + DBN + 4);
        @(negedge clk);
        load = 1'b0;
        idle(4);
        step_btn = 1'b0;
        idle(2 * DBN + 6);

        // Randomized mix of presses, loads and idle gaps.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: press($urandom_range(1, 2 * DBN + 4));
                1: do_load($urandom_range(0, 15));
                default: idle($urandom_range(0, 5));
            endcase
        end

`ifdef SEQ_AUTO_RUN_EN
        // Auto-run: 16 ticks in 80 cycles from 0, then restart mid-period.
        do_load(0);
        idle(2);
        @(negedge clk);
        n = cyc;
        run = 1'b1;
        for (int i = 1; i <= 16; i++) push_exp(i % 16, n + DIV * i + 1);
        exp_cnt = 0;
        repeat (80) @(negedge clk);
        run = 1'b0;
        idle(3);
        run = 1'b1;
        idle(2);
        run = 1'b0;
        idle(3);
        n = cyc;
        run = 1'b1;
        exp_cnt = 1;
        push_exp(1, n + DIV + 1);
        repeat (DIV + 2) @(negedge clk);
        run = 1'b0;
        idle(3);
`endif

        // Reset during PRESS_WAIT: async clear, no step for the straddling press.
        do_load(6);
        idle(2);
        @(negedge clk);
        step_btn = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_code", code_now(), 0);
        chk("async_reset_upd", int'(upd), 0);
        exp_cnt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(20);
        step_btn = 1'b0;
        idle(2 * DBN + 6);
        press(6);

        for (int k = 0; k < 50 && sbq.size() > 0; k++) @(negedge clk);
        chk("queue_drained", sbq.size(), 0);
        chk("final_code", code_now(), exp_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/abcd_sequencer.md
# abcd_sequencer

- Upstream stimulus stage for the Group 4 X/Y/Z decode logic.
- Turns a bouncy push-button, an optional free-running timer and a synchronous load into a registered 4-bit code.
- The code is driven on A, B, C, D, which connect one-to-one to the decoder's inputs.
- Lets the board or bench step through all 16 input combinations cleanly.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required to accept a button press or release; legal range 2..65535.
- AUTO_DIV, 5: auto-run period in clk cycles; legal range 2..2^24.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronous to clk externally.
- step_btn  in  1  raw asynchronous push-button, active high.
- load  in  1  synchronous load strobe, one cycle.
- load_val  in  4  value loaded when load=1; bit3→A … bit0→D.
- run  in  1  level; enables auto-stepping (see Configuration).
- A, B, C, D  out  1 each  registered code bits: A=cnt[3], B=cnt[2], C=cnt[1], D=cnt[0].
- upd  out  1  one-cycle pulse, coincident with the first cycle A..D hold a new value.

## Operation
- **Synchronizer:** 2-flop chain on step_btn (s1, s2).
- **Debounce FSM:** states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Debounce counter dc is 16-bit.
  - RELEASED: s2=1 → PRESS_WAIT, dc=0.
  - PRESS_WAIT:
    - s2=0 → RELEASED.
    - s2=1 and dc==DEBOUNCE_CYCLES-1 → PRESSED, assert internal step (registered, one cycle).
    - Otherwise dc++.
  - PRESSED: s2=0 → RELEASE_WAIT, dc=0.
  - RELEASE_WAIT:
    - s2=1 → PRESSED.
    - s2=0 and dc==DEBOUNCE_CYCLES-1 → RELEASED.
    - Otherwise dc++.
  - No step on release. A held button yields exactly one step.
- **Counter cnt[3:0], per-cycle priority:**
  1. load=1 → cnt=load_val.
  2. Else if step or tick → cnt=cnt+1 modulo 16 (15→0 wrap).
  3. Else hold.
- step and tick in the same cycle produce a single +1; both are consumed.
- A step or tick coincident with load is dropped, not queued.
- upd=1 in the cycle after any load/step/tick edge, including a load of the current value.
- **Reset values:**
  - cnt=0, so A=B=C=D=0.
  - upd=0.
  - s1=s2=0.
  - FSM=RELEASED, dc=0.
  - Prescaler=0, tick=0.
- Reset asserted mid-debounce or mid-prescale discards all progress. No step is emitted after reset for a press that began before it.

## Timing
- **Button latency:** take edge 0 as the first rising edge sampling step_btn=1.
  - s2=1 after edge 1; PRESS_WAIT entered at edge 2.
  - step registered at edge DEBOUNCE_CYCLES+2.
  - A..D update with upd=1 at edge DEBOUNCE_CYCLES+3.
- Button high for fewer than DEBOUNCE_CYCLES+1 consecutive synchronized cycles → no step.
- **Load latency:** A..D and upd change at the edge sampling load=1, i.e. 1 cycle.
- **Auto latency:** tick is registered; A..D change 1 cycle after tick.
- Minimum step spacing by button: 2·DEBOUNCE_CYCLES+2 cycles (press, release, press).

## Configuration
- **SEQ_AUTO_RUN_EN defined:** prescaler pc (24-bit) counts while run=1.
  - At pc==AUTO_DIV-1: pc=0 and tick=1 for one cycle.
  - run=0 clears pc to 0 and holds tick=0.
  - First tick comes AUTO_DIV cycles after run rises.
- **SEQ_AUTO_RUN_EN undefined:** prescaler logic absent, tick tied 0, run ignored. The port remains for pin compatibility.

## Structure
- Package abcd_seq_pkg:
  - CODE_W=4.
  - dbnc_state_t enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - DC_W=16, PC_W=24.
- Sub-module btn_debounce: synchronizer plus FSM, parameter DEBOUNCE_CYCLES, ports clk, rst_n, btn_raw, step_pulse.
- Top module holds counter, priority mux, prescaler and upd.

## Test plan
1. Reset, then step_btn held high 20 cycles (DEBOUNCE_CYCLES=4) → A..D go 0000→0001 exactly 7 edges after the first sampled high; one upd pulse; no further change while held or on release.
2. step_btn glitch high for 3 cycles, low, repeated 5 times → A..D stay 0000, upd never asserts.
3. load=1, load_val=4'b1111, then one clean press → ABCD=1111 then 0000 (wrap); upd pulses twice.
4. load=1 (load_val=4'b1010) in the same cycle the internal step fires → ABCD=1010, not 1011; single upd.
5. SEQ_AUTO_RUN_EN, AUTO_DIV=5, run=1 for 80 cycles from ABCD=0000 → increments every 5 cycles, 16 steps, ending 0000. run=0 mid-period, then run=1 → next tick 5 cycles after re-enable.
6. rst_n pulsed low during PRESS_WAIT with ABCD=0110 → outputs 0000 asynchronously; no step is generated after release of reset while the button stays high until released and pressed again.
